gb_cpu_decoder: RTL and testbench



---
 rtl/gb_cpu_common_pkg.sv | 72 +++++++
 rtl/gb_cpu_cb_decode.sv | 36 +++
 rtl/gb_cpu_decoder.sv | 350 +++++++++++++++++++++++++++++++++++
 tb/tb_gb_cpu_decoder.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_cpu_common_pkg.sv
// rtl/gb_cpu_common_pkg.sv - shared decode types and register/condition encodings for the SM83 decoder
package gb_cpu_common_pkg;

  typedef enum logic [4:0] {
    OP_NOP,
    OP_LD8,
    OP_LD16,
    OP_ALU8,
    OP_ALU16,
    OP_INCDEC8,
    OP_ROTA,
    OP_JUMP,
    OP_CALL,
    OP_RET,
    OP_RST,
    OP_STACK,
    OP_MISC,
    OP_CB_SHIFT,
    OP_CB_BIT,
    OP_CB_RES,
    OP_CB_SET,
    OP_ILLEGAL
  } op_class_t;

  localparam logic [2:0] R8_B      = 3'd0;
  localparam logic [2:0] R8_C      = 3'd1;
  localparam logic [2:0] R8_D      = 3'd2;
  localparam logic [2:0] R8_E      = 3'd3;
  localparam logic [2:0] R8_H      = 3'd4;
  localparam logic [2:0] R8_L      = 3'd5;
  localparam logic [2:0] R8_HL_IND = 3'd6;
  localparam logic [2:0] R8_A      = 3'd7;

  localparam logic [1:0] R16_BC = 2'd0;
  localparam logic [1:0] R16_DE = 2'd1;
  localparam logic [1:0] R16_HL = 2'd2;
  localparam logic [1:0] R16_SP = 2'd3;

  localparam logic [1:0] COND_NZ = 2'd0;
  localparam logic [1:0] COND_Z  = 2'd1;
  localparam logic [1:0] COND_NC = 2'd2;
  localparam logic [1:0] COND_C  = 2'd3;

  typedef struct packed {
    op_class_t   op_class;
    logic [2:0]  alu_op;
    logic [2:0]  dst_reg;
    logic [2:0]  src_reg;
    logic [1:0]  r16_sel;
    logic [1:0]  cond;
    logic        is_cond;
    logic [2:0]  bit_idx;
    logic [7:0]  imm8;
    logic [15:0] imm16;
    logic [1:0]  length;
    logic [2:0]  mcycles;
    logic [2:0]  mcycles_taken;
    logic        cb_prefix;
    logic        illegal;
  } decode_t;

  function automatic decode_t decode_nop();
    decode_t d;
    d               = '0;
    d.op_class      = OP_NOP;
    d.length        = 2'd1;
    d.mcycles       = 3'd1;
    d.mcycles_taken = 3'd1;
    return d;
  endfunction

endpackage

// File: rtl/gb_cpu_cb_decode.sv
// rtl/gb_cpu_cb_decode.sv - combinational decoder for the 0xCB-prefixed opcode table
module gb_cpu_cb_decode
  import gb_cpu_common_pkg::*;
(
  input  logic [7:0] cb_byte,
  input  logic [7:0] tail_byte,
  output decode_t    cb_dec
);

  always_comb begin
    cb_dec           = decode_nop();
    cb_dec.cb_prefix = 1'b1;
    cb_dec.length    = 2'd2;
    cb_dec.alu_op    = cb_byte[5:3];
    cb_dec.bit_idx   = cb_byte[5:3];
    cb_dec.dst_reg   = cb_byte[2:0];
    cb_dec.src_reg   = cb_byte[2:0];
    cb_dec.imm8      = cb_byte;
    cb_dec.imm16     = {tail_byte, cb_byte};

    unique case (cb_byte[7:6])
      2'b00:   cb_dec.op_class = OP_CB_SHIFT;
      2'b01:   cb_dec.op_class = OP_CB_BIT;
      2'b10:   cb_dec.op_class = OP_CB_RES;
      default: cb_dec.op_class = OP_CB_SET;
    endcase

    // BIT on (HL) only reads memory, the others read-modify-write it
    if (cb_byte[2:0] == R8_HL_IND)
      cb_dec.mcycles = (cb_byte[7:6] == 2'b01) ? 3'd3 : 3'd4;
    else
      cb_dec.mcycles = 3'd2;
    cb_dec.mcycles_taken = cb_dec.mcycles;
  end

endmodule

// File: rtl/gb_cpu_decoder.sv
// rtl/gb_cpu_decoder.sv - registered SM83 instruction decoder (base + CB tables)
// Define DECODER_TRACE_EN to print a per-cycle mnemonic trace in simulation.
module gb_cpu_decoder
  import gb_cpu_common_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] instruction,
  output logic [4:0]  op_class,
  output logic [2:0]  alu_op,
  output logic [2:0]  dst_reg,
  output logic [2:0]  src_reg,
  output logic [1:0]  r16_sel,
  output logic [1:0]  cond,
  output logic        is_cond,
  output logic [2:0]  bit_idx,
  output logic [7:0]  imm8,
  output logic [15:0] imm16,
  output logic [1:0]  length,
  output logic [2:0]  mcycles,
  output logic [2:0]  mcycles_taken,
  output logic        cb_prefix,
  output logic        illegal
);

  logic [7:0] byte0, byte1, byte2;
  logic [2:0] op_y, op_z;
  logic [1:0] op_p;
  logic       op_q;

  assign byte0 = instruction[23:16];
  assign byte1 = instruction[15:8];
  assign byte2 = instruction[7:0];
  assign op_y  = byte0[5:3];
  assign op_z  = byte0[2:0];
  assign op_p  = byte0[5:4];
  assign op_q  = byte0[3];

  decode_t base_dec, cb_dec, dec_d, dec_q;

  gb_cpu_cb_decode u_cb_decode (
    .cb_byte   (byte1),
    .tail_byte (byte2),
    .cb_dec    (cb_dec)
  );

  // Opcode split as x=[7:6], y=[5:3], z=[2:0], p=[5:4], q=[3]
  always_comb begin
    base_dec         = decode_nop();
    base_dec.alu_op  = op_y;
    base_dec.r16_sel = op_p;
    base_dec.imm8    = byte1;
    base_dec.imm16   = {byte2, byte1};

    unique case (byte0[7:6])
      2'b00: begin
        unique case (op_z)
          3'd0: begin
            if (op_y == 3'd1) begin
              base_dec.op_class = OP_LD16;
              base_dec.length   = 2'd3;
              base_dec.mcycles  = 3'd5;
            end else if (op_y == 3'd2) begin
              base_dec.op_class = OP_MISC;
              base_dec.length   = 2'd2;
            end else if (op_y == 3'd3) begin
              base_dec.op_class = OP_JUMP;
              base_dec.length   = 2'd2;
              base_dec.mcycles  = 3'd3;
            end else if (op_y[2]) begin
              base_dec.op_class      = OP_JUMP;
              base_dec.length        = 2'd2;
              base_dec.is_cond       = 1'b1;
              base_dec.cond          = op_y[1:0];
              base_dec.mcycles       = 3'd2;
              base_dec.mcycles_taken = 3'd3;
            end
          end
          3'd1: begin
            if (!op_q) begin
              base_dec.op_class = OP_LD16;
              base_dec.length   = 2'd3;
              base_dec.mcycles  = 3'd3;
            end else begin
              base_dec.op_class = OP_ALU16;
              base_dec.mcycles  = 3'd2;
            end
          end
          3'd2: begin
            base_dec.op_class = OP_LD8;
            base_dec.mcycles  = 3'd2;
            if (op_q) base_dec.dst_reg = R8_A;
            else      base_dec.src_reg = R8_A;
          end
          3'd3: begin
            base_dec.op_class = OP_ALU16;
            base_dec.mcycles  = 3'd2;
          end
          3'd4, 3'd5: begin
            base_dec.op_class = OP_INCDEC8;
            base_dec.dst_reg  = op_y;
            base_dec.src_reg  = op_y;
            base_dec.mcycles  = (op_y == R8_HL_IND) ? 3'd3 : 3'd1;
          end
          3'd6: begin
            base_dec.op_class = OP_LD8;
            base_dec.dst_reg  = op_y;
            base_dec.length   = 2'd2;
            base_dec.mcycles  = (op_y == R8_HL_IND) ? 3'd3 : 3'd2;
          end
          default: begin
            base_dec.op_class = op_y[2] ? OP_MISC : OP_ROTA;
          end
        endcase
      end

      2'b01: begin
        // The (HL),(HL) slot of the LD block is HALT
        if (byte0 == 8'h76) begin
          base_dec.op_class = OP_MISC;
        end else begin
          base_dec.op_class = OP_LD8;
          base_dec.dst_reg  = op_y;
          base_dec.src_reg  = op_z;
          base_dec.mcycles  = (op_y == R8_HL_IND || op_z == R8_HL_IND) ? 3'd2 : 3'd1;
        end
      end

      2'b10: begin
        base_dec.op_class = OP_ALU8;
        base_dec.dst_reg  = R8_A;
        base_dec.src_reg  = op_z;
        base_dec.mcycles  = (op_z == R8_HL_IND) ? 3'd2 : 3'd1;
      end

      default: begin
        unique case (op_z)
          3'd0: begin
            if (!op_y[2]) begin
              base_dec.op_class      = OP_RET;
              base_dec.is_cond       = 1'b1;
              base_dec.cond          = op_y[1:0];
              base_dec.mcycles       = 3'd2;
              base_dec.mcycles_taken = 3'd5;
            end else if (op_y == 3'd4 || op_y == 3'd6) begin
              base_dec.op_class = OP_LD8;
              base_dec.length   = 2'd2;
              base_dec.mcycles  = 3'd3;
              if (op_y == 3'd6) base_dec.dst_reg = R8_A;
              else              base_dec.src_reg = R8_A;
            end else if (op_y == 3'd5) begin
              base_dec.op_class = OP_ALU16;
              base_dec.r16_sel  = R16_SP;
              base_dec.length   = 2'd2;
              base_dec.mcycles  = 3'd4;
            end else begin
              base_dec.op_class = OP_LD16;
              base_dec.r16_sel  = R16_HL;
              base_dec.length   = 2'd2;
              base_dec.mcycles  = 3'd3;
            end
          end
          3'd1: begin
            if (!op_q) begin
              base_dec.op_class = OP_STACK;
              base_dec.mcycles  = 3'd3;
            end else if (op_p[1] == 1'b0) begin
              base_dec.op_class = OP_RET;
              base_dec.mcycles  = 3'd4;
            end else if (op_p == 2'd2) begin
              base_dec.op_class = OP_JUMP;
              base_dec.r16_sel  = R16_HL;
            end else begin
              base_dec.op_class = OP_LD16;
              base_dec.r16_sel  = R16_SP;
              base_dec.mcycles  = 3'd2;
            end
          end
          3'd2: begin
            if (!op_y[2]) begin
              base_dec.op_class      = OP_JUMP;
              base_dec.length        = 2'd3;
              base_dec.is_cond       = 1'b1;
              base_dec.cond          = op_y[1:0];
              base_dec.mcycles       = 3'd3;
              base_dec.mcycles_taken = 3'd4;
            end else begin
              base_dec.op_class = OP_LD8;
              base_dec.length   = op_y[0] ? 2'd3 : 2'd1;
              base_dec.mcycles  = op_y[0] ? 3'd4 : 3'd2;
              if (op_y[1]) base_dec.dst_reg = R8_A;
              else         base_dec.src_reg = R8_A;
            end
          end
          3'd3: begin
            if (op_y == 3'd0) begin
              base_dec.op_class = OP_JUMP;
              base_dec.length   = 2'd3;
              base_dec.mcycles  = 3'd4;
            end else if (op_y == 3'd6 || op_y == 3'd7) begin
              base_dec.op_class = OP_MISC;
            end else if (op_y != 3'd1) begin
              base_dec.op_class = OP_ILLEGAL;
              base_dec.illegal  = 1'b1;
            end
          end
          3'd4: begin
            if (!op_y[2]) begin
              base_dec.op_class      = OP_CALL;
              base_dec.length        = 2'd3;
              base_dec.is_cond       = 1'b1;
              base_dec.cond          = op_y[1:0];
              base_dec.mcycles       = 3'd3;
              base_dec.mcycles_taken = 3'd6;
            end else begin
              base_dec.op_class = OP_ILLEGAL;
              base_dec.illegal  = 1'b1;
            end
          end
          3'd5: begin
            if (!op_q) begin
              base_dec.op_class = OP_STACK;
              base_dec.mcycles  = 3'd4;
            end else if (op_p == 2'd0) begin
              base_dec.op_class = OP_CALL;
              base_dec.length   = 2'd3;
              base_dec.mcycles  = 3'd6;
            end else begin
              base_dec.op_class = OP_ILLEGAL;
              base_dec.illegal  = 1'b1;
            end
          end
          3'd6: begin
            base_dec.op_class = OP_ALU8;
            base_dec.dst_reg  = R8_A;
            base_dec.length   = 2'd2;
            base_dec.mcycles  = 3'd2;
          end
          default: begin
            base_dec.op_class = OP_RST;
            base_dec.imm8     = {2'b00, op_y, 3'b000};
            base_dec.mcycles  = 3'd4;
          end
        endcase
      end
    endcase

    if (!base_dec.is_cond) base_dec.mcycles_taken = base_dec.mcycles;
  end

  assign dec_d = (byte0 == 8'hCB) ? cb_dec : base_dec;

  always_ff @(posedge clk) begin
    if (!rst_n) dec_q <= decode_nop();
    else        dec_q <= dec_d;
  end

  assign op_class      = dec_q.op_class;
  assign alu_op        = dec_q.alu_op;
  assign dst_reg       = dec_q.dst_reg;
  assign src_reg       = dec_q.src_reg;
  assign r16_sel       = dec_q.r16_sel;
  assign cond          = dec_q.cond;
  assign is_cond       = dec_q.is_cond;
  assign bit_idx       = dec_q.bit_idx;
  assign imm8          = dec_q.imm8;
  assign imm16         = dec_q.imm16;
  assign length        = dec_q.length;
  assign mcycles       = dec_q.mcycles;
  assign mcycles_taken = dec_q.mcycles_taken;
  assign cb_prefix     = dec_q.cb_prefix;
  assign illegal       = dec_q.illegal;

`ifdef DECODER_TRACE_EN
  function automatic string r8_name(input logic [2:0] r);
    case (r)
      R8_B: return "B";
      R8_C: return "C";
      R8_D: return "D";
      R8_E: return "E";
      R8_H: return "H";
      R8_L: return "L";
      R8_HL_IND: return "(HL)";
      default: return "A";
    endcase
  endfunction

  function automatic string r16_name(input logic [1:0] r);
    case (r)
      R16_BC: return "BC";
      R16_DE: return "DE";
      R16_HL: return "HL";
      default: return "SP";
    endcase
  endfunction

  function automatic string cond_name(input logic [1:0] c);
    case (c)
      COND_NZ: return "NZ";
      COND_Z:  return "Z";
      COND_NC: return "NC";
      default: return "C";
    endcase
  endfunction

  function automatic string alu_name(input logic [2:0] a, input logic cb);
    string alu_tab [8] = '{"ADD", "ADC", "SUB", "SBC", "AND", "XOR", "OR", "CP"};
    string shf_tab [8] = '{"RLC", "RRC", "RL", "RR", "SLA", "SRA", "SWAP", "SRL"};
    return cb ? shf_tab[a] : alu_tab[a];
  endfunction

  function automatic string trace_text(input logic [7:0] op, input decode_t d);
    case (d.op_class)
      OP_ILLEGAL:  return "ILLEGAL";
      OP_NOP:      return "NOP";
      OP_CB_SHIFT: return $sformatf("%s %s", alu_name(d.alu_op, 1'b1), r8_name(d.src_reg));
      OP_CB_BIT:   return $sformatf("BIT %0d, %s", d.bit_idx, r8_name(d.src_reg));
      OP_CB_RES:   return $sformatf("RES %0d, %s", d.bit_idx, r8_name(d.src_reg));
      OP_CB_SET:   return $sformatf("SET %0d, %s", d.bit_idx, r8_name(d.src_reg));
      OP_LD8: begin
        if (op[7:6] == 2'b01) return $sformatf("LD %s, %s", r8_name(d.dst_reg), r8_name(d.src_reg));
        if (op[7:6] == 2'b00 && op[2:0] == 3'd6) return $sformatf("LD %s, n8", r8_name(d.dst_reg));
        return "LD8";
      end
      OP_LD16: begin
        if (op[7:6] == 2'b00 && op[3:0] == 4'h1) return $sformatf("LD %s, n16", r16_name(d.r16_sel));
        return "LD16";
      end
      OP_ALU8:    return $sformatf("%s A, %s", alu_name(d.alu_op, 1'b0), op[6] ? "n8" : r8_name(d.src_reg));
      OP_INCDEC8: return $sformatf("%s %s", op[0] ? "DEC" : "INC", r8_name(d.dst_reg));
      OP_JUMP, OP_CALL, OP_RET: begin
        string base;
        base = (d.op_class == OP_CALL) ? "CALL" : (d.op_class == OP_RET) ? "RET" :
               (d.length == 2'd2) ? "JR" : "JP";
        return d.is_cond ? $sformatf("%s %s", base, cond_name(d.cond)) : base;
      end
      OP_RST:  return $sformatf("RST %02Hh", d.imm8);
      OP_MISC: return (op == 8'h76) ? "HALT" : "MISC";
      default: return d.op_class.name();
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst_n)
      $display("[decode] %02h %02h %02h  %-14s len=%0d mc=%0d/%0d", byte0, byte1, byte2,
               trace_text(byte0, dec_d), dec_d.length, dec_d.mcycles, dec_d.mcycles_taken);
  end
`endif

endmodule

// File: tb/tb_gb_cpu_decoder.sv
// tb/tb_gb_cpu_decoder.sv - scoreboard bench for gb_cpu_decoder
module tb_gb_cpu_decoder;
  import gb_cpu_common_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] instruction;
  logic [4:0]  op_class;
  logic [2:0]  alu_op, dst_reg, src_reg, bit_idx, mcycles, mcycles_taken;
  logic [1:0]  r16_sel, cond, length;
  logic        is_cond, cb_prefix, illegal;
  logic [7:0]  imm8;
  logic [15:0] imm16;

  always #5 clk = ~clk;

  gb_cpu_decoder dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction),
    .op_class(op_class), .alu_op(alu_op), .dst_reg(dst_reg), .src_reg(src_reg),
    .r16_sel(r16_sel), .cond(cond), .is_cond(is_cond), .bit_idx(bit_idx),
    .imm8(imm8), .imm16(imm16), .length(length), .mcycles(mcycles),
    .mcycles_taken(mcycles_taken), .cb_prefix(cb_prefix), .illegal(illegal)
  );

  typedef struct {
    logic [7:0]  op;
    logic [4:0]  cls;
    logic        ck_cls;
    logic [1:0]  len;
    logic [2:0]  mc;
    logic [2:0]  mct;
    logic        ill;
    logic        cb;
    logic [7:0]  imm8;
    logic [15:0] imm16;
    logic [1:0]  cond;
    logic        is_cond;
    logic [2:0]  reg8;
    logic [2:0]  bit_idx;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Not-taken M-cycles of the base table, one row per high nibble (CB slot unused)
  string mc_tab [16] = '{
    "1322112152221121", "1322112132221121", "2322112122221121", "2322333122221121",
    "1111112111111121", "1111112111111121", "1111112111111121", "2222221211111121",
    "1111112111111121", "1111112111111121", "1111112111111121", "1111112111111121",
    "2334342424303624", "2331342424313124", "3321142441411124", "3321142432411124"
  };

  function automatic exp_t blank();
    exp_t e;
    e = '{op: 8'h00, cls: OP_NOP, ck_cls: 1'b1, len: 2'd1, mc: 3'd1, mct: 3'd1,
          ill: 1'b0, cb: 1'b0, imm8: 8'h00, imm16: 16'h0000, cond: 2'd0,
          is_cond: 1'b0, reg8: 3'd0, bit_idx: 3'd0};
    return e;
  endfunction

  function automatic logic [2:0] exp_mc(input logic [7:0] op);
    string row;
    logic [7:0] ch;
    row = mc_tab[op[7:4]];
    ch  = row.getc(int'(op[3:0]));
    return ch[2:0];
  endfunction

  function automatic logic [2:0] exp_mct(input logic [7:0] op);
    case (op)
      8'h20, 8'h28, 8'h30, 8'h38: return 3'd3;
      8'hC0, 8'hC8, 8'hD0, 8'hD8: return 3'd5;
      8'hC2, 8'hCA, 8'hD2, 8'hDA: return 3'd4;
      8'hC4, 8'hCC, 8'hD4, 8'hDC: return 3'd6;
      default: return exp_mc(op);
    endcase
  endfunction

  function automatic logic [1:0] exp_len(input logic [7:0] op);
    case (op)
      8'h01, 8'h11, 8'h21, 8'h31, 8'h08, 8'hC2, 8'hC3, 8'hC4, 8'hCA, 8'hCC, 8'hCD,
      8'hD2, 8'hD4, 8'hDA, 8'hDC, 8'hEA, 8'hFA: return 2'd3;
      8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E, 8'h10, 8'h18, 8'h20,
      8'h28, 8'h30, 8'h38, 8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
      8'hE0, 8'hF0, 8'hE8, 8'hF8: return 2'd2;
      default: return 2'd1;
    endcase
  endfunction

  task automatic drive(input logic [23:0] ins, input exp_t e);
    @(negedge clk);
    instruction = ins;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset(input logic [23:0] ins);
    exp_t e;
    e = blank();
    e.op = ins[23:16];
    @(negedge clk);
    rst_n = 1'b0;
    instruction = ins;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_cmp++; if (op_class !== e.cls) begin n_bad++; $display("FAIL reset_class ins=%06h got=%0d want=%0d", ins, op_class, e.cls); end
    n_cmp++; if (length !== e.len) begin n_bad++; $display("FAIL reset_len ins=%06h got=%0d want=%0d", ins, length, e.len); end
    n_cmp++; if (mcycles !== e.mc) begin n_bad++; $display("FAIL reset_mc ins=%06h got=%0d want=%0d", ins, mcycles, e.mc); end
    n_cmp++; if (mcycles_taken !== e.mct) begin n_bad++; $display("FAIL reset_mct ins=%06h got=%0d want=%0d", ins, mcycles_taken, e.mct); end
    n_cmp++; if (illegal !== e.ill) begin n_bad++; $display("FAIL reset_illegal ins=%06h got=%0b want=%0b", ins, illegal, e.ill); end
    n_cmp++; if (cb_prefix !== e.cb) begin n_bad++; $display("FAIL reset_cb ins=%06h got=%0b want=%0b", ins, cb_prefix, e.cb); end
    n_cmp++; if (imm16 !== e.imm16) begin n_bad++; $display("FAIL reset_imm16 ins=%06h got=%04h want=%04h", ins, imm16, e.imm16); end
    n_cmp++; if (is_cond !== e.is_cond) begin n_bad++; $display("FAIL reset_is_cond ins=%06h got=%0b want=%0b", ins, is_cond, e.is_cond); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_base_sweep();
    exp_t e;
    logic [7:0] b1, b2;
    for (int i = 0; i < 256; i++) begin
      if (i == 8'hCB) continue;
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      e = blank();
      e.op = 8'(i);
      e.ill = e.op inside {8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB, 8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD};
      e.len = exp_len(e.op);
      e.mc = exp_mc(e.op);
      e.mct = exp_mct(e.op);
      e.imm16 = {b2, b1};
      e.imm8 = ((e.op & 8'hC7) == 8'hC7) ? (e.op & 8'h38) : b1;
      e.ck_cls = 1'b1;
      case (e.op)
        8'h00: e.cls = OP_NOP;
        8'h01: e.cls = OP_LD16;
        8'h04: e.cls = OP_INCDEC8;
        8'h07: e.cls = OP_ROTA;
        8'h40: e.cls = OP_LD8;
        8'h76: e.cls = OP_MISC;
        8'h87: e.cls = OP_ALU8;
        8'hC5: e.cls = OP_STACK;
        8'hCD: e.cls = OP_CALL;
        8'hD3: e.cls = OP_ILLEGAL;
        8'hD9: e.cls = OP_RET;
        8'hE9: e.cls = OP_JUMP;
        default: e.ck_cls = 1'b0;
      endcase
      drive({e.op, b1, b2}, e);
      e = sb.pop_front();
      n_cmp++; if (illegal !== e.ill) begin n_bad++; $display("FAIL base_illegal op=%02h got=%0b want=%0b", e.op, illegal, e.ill); end
      n_cmp++; if (length !== e.len) begin n_bad++; $display("FAIL base_len op=%02h got=%0d want=%0d", e.op, length, e.len); end
      n_cmp++; if (mcycles !== e.mc) begin n_bad++; $display("FAIL base_mc op=%02h got=%0d want=%0d", e.op, mcycles, e.mc); end
      n_cmp++; if (mcycles_taken !== e.mct) begin n_bad++; $display("FAIL base_mct op=%02h got=%0d want=%0d", e.op, mcycles_taken, e.mct); end
      n_cmp++; if (imm8 !== e.imm8) begin n_bad++; $display("FAIL base_imm8 op=%02h got=%02h want=%02h", e.op, imm8, e.imm8); end
      n_cmp++; if (imm16 !== e.imm16) begin n_bad++; $display("FAIL base_imm16 op=%02h got=%04h want=%04h", e.op, imm16, e.imm16); end
      n_cmp++; if (cb_prefix !== 1'b0) begin n_bad++; $display("FAIL base_cb op=%02h got=%0b want=0", e.op, cb_prefix); end
      if (e.ck_cls) begin
        n_cmp++; if (op_class !== e.cls) begin n_bad++; $display("FAIL base_class op=%02h got=%0d want=%0d", e.op, op_class, e.cls); end
      end
    end
  endtask

  task automatic test_conditionals();
    exp_t e;
    exp_t tab [$];
    e = blank(); e.op = 8'h20; e.cls = OP_JUMP; e.cond = 2'd0; e.is_cond = 1'b1; e.len = 2'd2; e.mc = 3'd2; e.mct = 3'd3; tab.push_back(e);
    e = blank(); e.op = 8'h38; e.cls = OP_JUMP; e.cond = 2'd3; e.is_cond = 1'b1; e.len = 2'd2; e.mc = 3'd2; e.mct = 3'd3; tab.push_back(e);
    e = blank(); e.op = 8'hC4; e.cls = OP_CALL; e.cond = 2'd0; e.is_cond = 1'b1; e.len = 2'd3; e.mc = 3'd3; e.mct = 3'd6; tab.push_back(e);
    e = blank(); e.op = 8'hDC; e.cls = OP_CALL; e.cond = 2'd3; e.is_cond = 1'b1; e.len = 2'd3; e.mc = 3'd3; e.mct = 3'd6; tab.push_back(e);
    e = blank(); e.op = 8'hC0; e.cls = OP_RET;  e.cond = 2'd0; e.is_cond = 1'b1; e.len = 2'd1; e.mc = 3'd2; e.mct = 3'd5; tab.push_back(e);
    e = blank(); e.op = 8'hCA; e.cls = OP_JUMP; e.cond = 2'd1; e.is_cond = 1'b1; e.len = 2'd3; e.mc = 3'd3; e.mct = 3'd4; tab.push_back(e);
    e = blank(); e.op = 8'hC9; e.cls = OP_RET;  e.cond = 2'd0; e.is_cond = 1'b0; e.len = 2'd1; e.mc = 3'd4; e.mct = 3'd4; tab.push_back(e);
    foreach (tab[i]) begin
      drive({tab[i].op, 16'hA55A}, tab[i]);
      e = sb.pop_front();
      n_cmp++; if (op_class !== e.cls) begin n_bad++; $display("FAIL cond_class op=%02h got=%0d want=%0d", e.op, op_class, e.cls); end
      n_cmp++; if (is_cond !== e.is_cond) begin n_bad++; $display("FAIL cond_is_cond op=%02h got=%0b want=%0b", e.op, is_cond, e.is_cond); end
      if (e.is_cond) begin
        n_cmp++; if (cond !== e.cond) begin n_bad++; $display("FAIL cond_field op=%02h got=%0d want=%0d", e.op, cond, e.cond); end
      end
      n_cmp++; if (length !== e.len) begin n_bad++; $display("FAIL cond_len op=%02h got=%0d want=%0d", e.op, length, e.len); end
      n_cmp++; if (mcycles !== e.mc) begin n_bad++; $display("FAIL cond_mc op=%02h got=%0d want=%0d", e.op, mcycles, e.mc); end
      n_cmp++; if (mcycles_taken !== e.mct) begin n_bad++; $display("FAIL cond_mct op=%02h got=%0d want=%0d", e.op, mcycles_taken, e.mct); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e, prev;
    logic [15:0] v;
    prev = blank();
    for (int i = 0; i < 10; i++) begin
      e = blank();
      v = 16'($urandom);
      if (i % 2 == 0) begin
        e.op = 8'h08; e.cls = OP_LD16; e.len = 2'd3; e.mc = 3'd5; e.mct = 3'd5;
      end
      e.imm16 = v;
      @(negedge clk);
      instruction = {e.op, v[7:0], v[15:8]};
      sb.push_back(e);
      if (i > 0) begin
        #1;
        n_cmp++; if (length !== prev.len) begin n_bad++; $display("FAIL b2b_hold step=%0d got=%0d want=%0d", i, length, prev.len); end
      end
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_cmp++; if (op_class !== e.cls) begin n_bad++; $display("FAIL b2b_class step=%0d got=%0d want=%0d", i, op_class, e.cls); end
      n_cmp++; if (length !== e.len) begin n_bad++; $display("FAIL b2b_len step=%0d got=%0d want=%0d", i, length, e.len); end
      n_cmp++; if (mcycles !== e.mc) begin n_bad++; $display("FAIL b2b_mc step=%0d got=%0d want=%0d", i, mcycles, e.mc); end
      n_cmp++; if (imm16 !== e.imm16) begin n_bad++; $display("FAIL b2b_imm16 step=%0d got=%04h want=%04h", i, imm16, e.imm16); end
      prev = e;
    end
  endtask

  task automatic test_cb_sweep();
    exp_t e;
    logic [7:0] b1, b2;
    for (int i = 0; i < 256; i++) begin
      b1 = 8'(i);
      b2 = 8'($urandom);
      e = blank();
      e.op = b1;
      e.cb = 1'b1;
      e.len = 2'd2;
      e.reg8 = b1[2:0];
      e.bit_idx = b1[5:3];
      e.imm8 = b1;
      e.imm16 = {b2, b1};
      case (b1[7:6])
        2'b00: e.cls = OP_CB_SHIFT;
        2'b01: e.cls = OP_CB_BIT;
        2'b10: e.cls = OP_CB_RES;
        default: e.cls = OP_CB_SET;
      endcase
      if (b1[2:0] == 3'd6) e.mc = (b1[7:6] == 2'b01) ? 3'd3 : 3'd4;
      else                 e.mc = 3'd2;
      e.mct = e.mc;
      drive({8'hCB, b1, b2}, e);
      e = sb.pop_front();
      n_cmp++; if (op_class !== e.cls) begin n_bad++; $display("FAIL cb_class b1=%02h got=%0d want=%0d", e.op, op_class, e.cls); end
      n_cmp++; if (dst_reg !== e.reg8) begin n_bad++; $display("FAIL cb_dst b1=%02h got=%0d want=%0d", e.op, dst_reg, e.reg8); end
      n_cmp++; if (src_reg !== e.reg8) begin n_bad++; $display("FAIL cb_src b1=%02h got=%0d want=%0d", e.op, src_reg, e.reg8); end
      n_cmp++; if (bit_idx !== e.bit_idx) begin n_bad++; $display("FAIL cb_bit b1=%02h got=%0d want=%0d", e.op, bit_idx, e.bit_idx); end
      n_cmp++; if (alu_op !== e.bit_idx) begin n_bad++; $display("FAIL cb_alu b1=%02h got=%0d want=%0d", e.op, alu_op, e.bit_idx); end
      n_cmp++; if (length !== e.len) begin n_bad++; $display("FAIL cb_len b1=%02h got=%0d want=%0d", e.op, length, e.len); end
      n_cmp++; if (mcycles !== e.mc) begin n_bad++; $display("FAIL cb_mc b1=%02h got=%0d want=%0d", e.op, mcycles, e.mc); end
      n_cmp++; if (mcycles_taken !== e.mct) begin n_bad++; $display("FAIL cb_mct b1=%02h got=%0d want=%0d", e.op, mcycles_taken, e.mct); end
      n_cmp++; if (cb_prefix !== e.cb) begin n_bad++; $display("FAIL cb_prefix b1=%02h got=%0b want=%0b", e.op, cb_prefix, e.cb); end
      n_cmp++; if (illegal !== e.ill) begin n_bad++; $display("FAIL cb_illegal b1=%02h got=%0b want=%0b", e.op, illegal, e.ill); end
      n_cmp++; if (imm16 !== e.imm16) begin n_bad++; $display("FAIL cb_imm16 b1=%02h got=%04h want=%04h", e.op, imm16, e.imm16); end
    end
  endtask

  task automatic test_vectors();
    exp_t e;
    exp_t tab [$];
    e = blank(); e.op = 8'hFF; e.cls = OP_RST; e.imm8 = 8'h38; e.imm16 = 16'h0055; e.mc = 3'd4; e.mct = 3'd4; tab.push_back(e);
    e = blank(); e.op = 8'hC7; e.cls = OP_RST; e.imm8 = 8'h00; e.imm16 = 16'h0055; e.mc = 3'd4; e.mct = 3'd4; tab.push_back(e);
    e = blank(); e.op = 8'hEF; e.cls = OP_RST; e.imm8 = 8'h28; e.imm16 = 16'h0055; e.mc = 3'd4; e.mct = 3'd4; tab.push_back(e);
    e = blank(); e.op = 8'h01; e.cls = OP_LD16; e.imm8 = 8'h34; e.imm16 = 16'h1234; e.len = 2'd3; e.mc = 3'd3; e.mct = 3'd3; tab.push_back(e);
    foreach (tab[i]) begin
      drive({tab[i].op, tab[i].imm16[7:0], tab[i].imm16[15:8]}, tab[i]);
      e = sb.pop_front();
      n_cmp++; if (op_class !== e.cls) begin n_bad++; $display("FAIL vec_class op=%02h got=%0d want=%0d", e.op, op_class, e.cls); end
      n_cmp++; if (imm8 !== e.imm8) begin n_bad++; $display("FAIL vec_imm8 op=%02h got=%02h want=%02h", e.op, imm8, e.imm8); end
      n_cmp++; if (imm16 !== e.imm16) begin n_bad++; $display("FAIL vec_imm16 op=%02h got=%04h want=%04h", e.op, imm16, e.imm16); end
      n_cmp++; if (length !== e.len) begin n_bad++; $display("FAIL vec_len op=%02h got=%0d want=%0d", e.op, length, e.len); end
      n_cmp++; if (mcycles !== e.mc) begin n_bad++; $display("FAIL vec_mc op=%02h got=%0d want=%0d", e.op, mcycles, e.mc); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    instruction = 24'hCD1234;
    repeat (2) @(posedge clk);
    test_reset(24'hCD1234);
    test_base_sweep();
    test_conditionals();
    test_back_to_back();
    test_cb_sweep();
    test_vectors();
    test_reset(24'hCBFF00);
    test_reset(24'hD31234);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
